requant_pipe: RTL
=================

# requant_pipe

Elastic, multi-lane requantizer that converts signed IN_W-bit accumulator results to signed OUT_W-bit activations. It applies a runtime-configurable arithmetic right shift with optional round-half-up, optional ReLU, and saturation. It sits between the convolution/accumulator output and the next layer's input buffer, with valid/ready handshakes on both sides. A saturation event counter is provided for quantization-range tuning.

## Interface
- IN_W, 32, signed input lane width
- OUT_W, 8, signed output lane width (OUT_W < IN_W)
- SIZE, 4, number of parallel lanes per beat
- SHIFT_W, 5, width of shift amount; legal shift 0..IN_W-1
- CNT_W, 16, saturation counter width

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cfg_load  in  1  load configuration (accepted only when idle=1)
- cfg_shift  in  SHIFT_W  right-shift amount
- cfg_round  in  1  0 = truncate (floor), 1 = round-half-up
- cfg_relu  in  1  1 = clamp negative results to 0
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept beat
- pixel_in  in  IN_W*SIZE  lane i = bits [IN_W*i +: IN_W], two's complement
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- pixel_out  out  OUT_W*SIZE  lane i = bits [OUT_W*i +: OUT_W]
- idle  out  1  both pipeline stages empty
- sat_count  out  CNT_W  beats with ≥1 saturated lane, sticks at max
- sat_clear  in  1  zero sat_count

## Operation
- Config registers (shift, round, relu) reset to 0/0/0. They load on cfg_load && idle. cfg_load while not idle is ignored with no side effect. The config used for a beat is whatever is registered at stage-1 capture.
- Stage 1 (capture/shift), per lane, computed in IN_W+1 bits to avoid round overflow:
  - x = sign-extend(pixel_in lane).
  - Truncate: y = x >>> s.
  - Round with s>0: y = (x + 2^(s-1)) >>> s.
  - Round with s=0: y = x.
- Stage 2 (clip), per lane:
  - If relu and y<0, then y=0.
  - If y > 2^(OUT_W-1)-1, output MAX and flag saturation.
  - If y < -2^(OUT_W-1), output MIN and flag saturation.
  - Otherwise output y[OUT_W-1:0].
  - A ReLU clamp alone is not saturation.
- Elastic handshake:
  - in_ready = !v1 || ready2, where ready2 = !v2 || out_ready.
  - Stage 2 loads when ready2. out_valid = v2.
  - A transfer occurs on any cycle where valid && ready on that interface.
- pixel_out is held stable while out_valid && !out_ready.
- sat_count increments by 1 on each output transfer whose beat has any lane flagged, saturating at 2^CNT_W-1.
- sat_clear takes priority over an increment in the same cycle.
- Reset:
  - v1 = v2 = 0, so out_valid = 0.
  - pixel_out = 0, sat_count = 0, config = 0, idle = 1, in_ready = 1.
  - Reset mid-stream discards in-flight beats without emitting them.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1 (2 register stages) when out_ready is held high.
- Throughput is 1 beat/cycle sustained with out_ready=1. There are no bubbles on back-pressure release.
- Full condition (v1 && v2 && !out_ready): in_ready=0 combinationally in the same cycle. No beat is ever dropped or duplicated.
- On simultaneous output transfer and input transfer when full, the pipeline shifts and a new beat is accepted in the same cycle.
- idle is registered-state-derived: idle = !v1 && !v2.

## Test plan
- Reset then truncate, shift=8, out_ready=1: lanes {0x00001234, 0xFFFFEDCC, 0x00007F00, 0x00000000} -> {0x12, 0xED, 0x7F, 0x00} two cycles later; sat_count=0.
- Round mode, shift=4: lanes {24, 23, -24, -25} -> {2, 1, -1, -2}. Truncate mode on the same inputs -> {1, 1, -2, -2}.
- Saturation and ReLU, shift=0, relu=1: lanes {300, -300, -5, 127} -> {127, 0, 0, 127}, sat_count=1. With relu=0 -> {127, -128, -5, 127}, sat_count=2.
- Back-pressure: stream 10 incrementing beats, toggle out_ready 1010... -> in_ready drops when both stages are full, output order is preserved, exactly 10 beats out, and pixel_out is stable while stalled.
- Config gating: cfg_load(shift=2) with pipeline non-idle -> ignored and beats use the old shift. Repeat with idle=1 -> applied. Assert reset mid-stream -> out_valid=0 next cycle and no stale beat afterwards.
- Counter: force 2^CNT_W+3 saturating beats -> sat_count sticks at 0xFFFF. sat_clear together with a saturating beat -> 0.

Source files
------------

// File: rtl/requant_pipe_if.sv
// Valid/ready streaming bundle for the requantizer: accumulator beats in, activation beats out.
interface requant_pipe_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int SIZE  = 4
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic [IN_W*SIZE-1:0]    pixel_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W*SIZE-1:0]   pixel_out;

    modport master (
        output in_valid, pixel_in, out_ready,
        input  in_ready, out_valid, pixel_out
    );

    modport slave (
        input  in_valid, pixel_in, out_ready,
        output in_ready, out_valid, pixel_out
    );
endinterface

// File: rtl/requant_pipe.sv
// Two-stage elastic requantizer: shift/round in stage 1, ReLU/saturate in stage 2,
// plus a sticky saturation-event counter for quantization range tuning.
module requant_pipe #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SIZE    = 4,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_round,
    input  logic               cfg_relu,
    requant_pipe_if.slave      bus,
    output logic               idle,
    output logic [CNT_W-1:0]   sat_count,
    input  logic               sat_clear
);
    localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] MIN_V = -MAX_V - 1;

    logic [SHIFT_W-1:0]      shift_q;
    logic                    round_q;
    logic                    relu_q;

    logic                    v1;
    logic                    v2;
    logic                    ready2;
    logic                    relu1;
    logic                    sat2;
    logic [OUT_W*SIZE-1:0]   pixel_q;

    logic signed [IN_W:0]    bias;
    logic signed [IN_W:0]    x_ext   [SIZE];
    logic signed [IN_W:0]    y1_next [SIZE];
    logic signed [IN_W:0]    y1      [SIZE];
    logic signed [IN_W:0]    y_relu  [SIZE];
    logic [OUT_W*SIZE-1:0]   clip_next;
    logic [SIZE-1:0]         sat_lane;

    assign ready2        = !v2 || bus.out_ready;
    assign bus.in_ready  = !v1 || ready2;
    assign bus.out_valid = v2;
    assign bus.pixel_out = pixel_q;
    assign idle          = !v1 && !v2;

    // One extra bit of headroom keeps the rounding bias from wrapping large positives.
    always_comb begin
        bias = '0;
        if (round_q && (shift_q != '0)) begin
            bias = (IN_W+1)'(1) << (shift_q - SHIFT_W'(1));
        end
        for (int i = 0; i < SIZE; i++) begin
            x_ext[i]   = $signed({bus.pixel_in[IN_W*i + IN_W - 1], bus.pixel_in[IN_W*i +: IN_W]});
            y1_next[i] = (x_ext[i] + bias) >>> shift_q;
        end
    end

    // ReLU zeroing is a clamp by design, so it never raises a saturation flag.
    always_comb begin
        clip_next = '0;
        sat_lane  = '0;
        for (int i = 0; i < SIZE; i++) begin
            y_relu[i] = (relu1 && (y1[i] < 0)) ? '0 : y1[i];
            if (y_relu[i] > MAX_V) begin
                clip_next[OUT_W*i +: OUT_W] = MAX_V[OUT_W-1:0];
                sat_lane[i]                 = 1'b1;
            end else if (y_relu[i] < MIN_V) begin
                clip_next[OUT_W*i +: OUT_W] = MIN_V[OUT_W-1:0];
                sat_lane[i]                 = 1'b1;
            end else begin
                clip_next[OUT_W*i +: OUT_W] = y_relu[i][OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            round_q <= 1'b0;
            relu_q  <= 1'b0;
        end else if (cfg_load && idle) begin
            shift_q <= cfg_shift;
            round_q <= cfg_round;
            relu_q  <= cfg_relu;
        end
    end

    // The ReLU setting travels with the beat so a later config load cannot alter it.
    always_ff @(posedge clock) begin
        if (reset) begin
            v1    <= 1'b0;
            relu1 <= 1'b0;
            for (int i = 0; i < SIZE; i++) y1[i] <= '0;
        end else if (bus.in_ready) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                relu1 <= relu_q;
                for (int i = 0; i < SIZE; i++) y1[i] <= y1_next[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v2      <= 1'b0;
            sat2    <= 1'b0;
            pixel_q <= '0;
        end else if (ready2) begin
            v2 <= v1;
            if (v1) begin
                pixel_q <= clip_next;
                sat2    <= |sat_lane;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || sat_clear) begin
            sat_count <= '0;
        end else if (v2 && bus.out_ready && sat2 && (sat_count != '1)) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end
endmodule
